// File: rtl/instr_sequencer.sv
// instr_sequencer: queues host instructions and issues them to the control unit over Run/Done
module instr_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [13:0]              in_instr,
  input  logic                     go,
  input  logic                     err_clr,
  output logic                     Run,
  output logic [1:0]               Rx,
  output logic [1:0]               Ry,
  output logic [1:0]               Fun,
  output logic [7:0]               Data,
  input  logic                     Done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              retired,
  output logic                     err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [13:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          run_q, run_d, err_q, err_d;
  logic [1:0]    rx_q, rx_d, ry_q, ry_d, fun_q, fun_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   retired_q, retired_d;
  logic          full, push, pop;
  logic [13:0]   head;

  assign full        = count_q == (AW+1)'(DEPTH);
  assign push        = in_valid && !full;
  assign pop         = state_q == IDLE && go && count_q != '0;
  assign head        = mem_q[rptr_q];
  assign in_ready    = !full;
  assign Run         = run_q;
  assign Rx          = rx_q;
  assign Ry          = ry_q;
  assign Fun         = fun_q;
  assign Data        = data_q;
  assign busy        = state_q == WAIT;
  assign count       = count_q;
  assign retired     = retired_q;
  assign err_timeout = err_q;

  // FIFO storage; contents need no reset because occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_instr;
  end

  // FIFO bookkeeping, issue FSM and watchdog next-state
  always_comb begin
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    count_d   = (push && !pop) ? count_q + 1'b1 : (!push && pop) ? count_q - 1'b1 : count_q;
    state_d   = state_q;
    timer_d   = timer_q;
    run_d     = 1'b0;
    rx_d      = rx_q;
    ry_d      = ry_q;
    fun_d     = fun_q;
    data_d    = data_q;
    retired_d = retired_q;
    err_d     = err_q && !err_clr;
    if (state_q == IDLE) begin
      if (pop) begin
        fun_d   = head[13:12];
        rx_d    = head[11:10];
        ry_d    = head[9:8];
        data_d  = head[13:12] == 2'b00 ? head[7:0] : 8'h00;
        run_d   = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
    end else if (Done) begin
      retired_d = retired_q + 16'd1;
      state_d   = IDLE;
    end else if (timer_q == TW'(TIMEOUT - 1)) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      run_q     <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      fun_q     <= '0;
      data_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      run_q     <= run_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      fun_q     <= fun_d;
      data_q    <= data_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, go, err_clr, Run, Done, busy, err_timeout;
  logic [13:0] in_instr;
  logic [1:0]  Rx, Ry, Fun;
  logic [7:0]  Data;
  logic [2:0]  count;
  logic [15:0] retired;
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_ret = 0;
  bit          ok;

  instr_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .go(go), .err_clr(err_clr), .Run(Run), .Rx(Rx), .Ry(Ry), .Fun(Fun), .Data(Data),
    .Done(Done), .busy(busy), .count(count), .retired(retired), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] w);
    in_valid = 1'b1;
    in_instr = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_run(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (Run) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_fields(input string tag, input logic [1:0] f, input logic [1:0] x,
                              input logic [1:0] y, input logic [7:0] d);
    check({tag, "_fun"}, 32'(Fun), 32'(f));
    check({tag, "_rx"}, 32'(Rx), 32'(x));
    check({tag, "_ry"}, 32'(Ry), 32'(y));
    check({tag, "_data"}, 32'(Data), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] words [4];
    logic [1:0]  ef [4];
    logic [1:0]  ex [4];
    logic [1:0]  ey [4];
    logic [7:0]  ed [4];
    words = '{14'h1B00, 14'h0433, 14'h31AA, 14'h2E77};
    ef = '{2'd1, 2'd0, 2'd3, 2'd2};
    ex = '{2'd2, 2'd1, 2'd0, 2'd3};
    ey = '{2'd3, 2'd0, 2'd1, 2'd2};
    ed = '{8'h00, 8'h33, 8'h00, 8'h00};
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; go = 1'b1; err_clr = 1'b0; Done = 1'b0;
    step(); step();
    check("rst_run", 32'(Run), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_ready", 32'(in_ready), 1);
    check_fields("rst", 2'd0, 2'd0, 2'd0, 8'h00);
    reset = 1'b1;
    step();
    // first instruction: latency and handshake
    push(14'h005A);
    check("lat_run0", 32'(Run), 0);
    check("lat_count", 32'(count), 1);
    step();
    check("lat_run1", 32'(Run), 1);
    check("lat_busy", 32'(busy), 1);
    check_fields("load", 2'd0, 2'd0, 2'd0, 8'h5A);
    step();
    check("lat_run2", 32'(Run), 0);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    check("t1_retired", 32'(retired), 32'(exp_ret));
    check("t1_busy", 32'(busy), 0);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("idle_done_ignored", 32'(retired), 32'(exp_ret));
    // fill the FIFO with go low, overflow push dropped
    go = 1'b0;
    for (int i = 0; i < 4; i++) push(words[i]);
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(in_ready), 0);
    push(14'h0099);
    check("overflow_count", 32'(count), 4);
    check("go_low_run", 32'(Run), 0);
    go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_run(4, ok);
      check("q_run_seen", 32'(ok), 1);
      check_fields("q", ef[i], ex[i], ey[i], ed[i]);
      step();
      check("q_run_pulse", 32'(Run), 0);
      check_fields("q_hold", ef[i], ex[i], ey[i], ed[i]);
      Done = 1'b1;
      step();
      Done = 1'b0;
      exp_ret++;
      check("q_busy", 32'(busy), 0);
      check("q_gap", 32'(Run), 0);
    end
    check("q_retired", 32'(retired), 32'(exp_ret));
    check("q_count", 32'(count), 0);
    step(); step();
    check("q_no_extra_run", 32'(Run), 0);
    // add instruction clears Data, fields held
    push(14'h26FF);
    wait_run(4, ok);
    check("add_run_seen", 32'(ok), 1);
    check_fields("add", 2'd2, 2'd1, 2'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check_fields("add_hold", 2'd2, 2'd1, 2'd2, 8'h00);
    end
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    check("add_retired", 32'(retired), 32'(exp_ret));
    // watchdog timeout, next instruction still issues
    push(14'h0011);
    wait_run(4, ok);
    check("to_run_seen", 32'(ok), 1);
    for (int i = 0; i < 15; i++) begin
      in_valid = i == 0;
      in_instr = 14'h0522;
      step();
    end
    in_valid = 1'b0;
    check("to_busy_before", 32'(busy), 1);
    check("to_err_before", 32'(err_timeout), 0);
    check("to_count_pending", 32'(count), 1);
    step();
    check("to_err", 32'(err_timeout), 1);
    check("to_busy", 32'(busy), 0);
    check("to_retired", 32'(retired), 32'(exp_ret));
    wait_run(4, ok);
    check("to_next_run", 32'(ok), 1);
    check_fields("to_next", 2'd0, 2'd1, 2'd1, 8'h22);
    check("to_err_kept", 32'(err_timeout), 1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    check("to_next_retired", 32'(retired), 32'(exp_ret));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr", 32'(err_timeout), 0);
    // Done on the timeout cycle wins
    push(14'h0633);
    wait_run(4, ok);
    check("dto_run_seen", 32'(ok), 1);
    for (int i = 0; i < 15; i++) step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    check("dto_err", 32'(err_timeout), 0);
    check("dto_retired", 32'(retired), 32'(exp_ret));
    check("dto_busy", 32'(busy), 0);
    // timeout set beats err_clr in the same cycle
    push(14'h0701);
    wait_run(4, ok);
    check("sw_run_seen", 32'(ok), 1);
    for (int i = 0; i < 15; i++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("set_wins_err", 32'(err_timeout), 1);
    check("set_wins_retired", 32'(retired), 32'(exp_ret));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("set_wins_clr", 32'(err_timeout), 0);
    // Done in the same cycle as Run is accepted
    push(14'h0402);
    wait_run(4, ok);
    check("fd_run_seen", 32'(ok), 1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    check("fd_retired", 32'(retired), 32'(exp_ret));
    check("fd_busy", 32'(busy), 0);
    // reset mid-WAIT with two words queued
    push(14'h0003);
    wait_run(4, ok);
    check("mr_run_seen", 32'(ok), 1);
    push(14'h0004);
    push(14'h0005);
    check("mr_count", 32'(count), 2);
    check("mr_busy", 32'(busy), 1);
    reset = 1'b0;
    step();
    check("mr_run", 32'(Run), 0);
    check("mr_count0", 32'(count), 0);
    check("mr_retired", 32'(retired), 0);
    check("mr_busy0", 32'(busy), 0);
    check("mr_ready", 32'(in_ready), 1);
    reset = 1'b1;
    step(); step();
    check("mr_idle_after", 32'(Run), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
